// File: rtl/controller_pkg.sv
// ============================================================================
// controller_pkg : shared FSM encodings, channel indices and sizing helper
// Rev 1.0
// ============================================================================
`default_nettype none

package controller_pkg;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] PRESS_PEND = 2'd1;
    localparam logic [1:0] HELD       = 2'd2;
    localparam logic [1:0] REL_PEND   = 2'd3;

    localparam int CH_LEFT   = 0;
    localparam int CH_RIGHT  = 1;
    localparam int CH_UP     = 2;
    localparam int CH_DOWN   = 3;
    localparam int CH_ATTACK = 4;
    localparam int CH_PARRY  = 5;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
// debounce_channel : 2-flop sync, polarity normalise, debounce FSM, pulses
// Optional auto-repeat in HELD under CTRL_AUTO_REPEAT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module debounce_channel
    import controller_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 10,
    parameter int ACTIVE_LOW     = 1,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_RATE    = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic raw_i,
    output logic level_o,
    output logic level_d_o,
    output logic press_o,
    output logic release_o
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_TICKS, REPEAT_DELAY, REPEAT_RATE);
    localparam logic             IDLE_LVL = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       sync_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d, press_evt;
    logic             release_q, release_d;
    logic             pressed_now;

    assign pressed_now = sync_q[1] ^ IDLE_LVL;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (tick_i) begin
            case (state_q)
                IDLE: begin
                    if (pressed_now) begin
                        if (DEBOUNCE_TICKS == 1) begin
                            state_d = HELD;
                            press_d = 1'b1;
                        end else begin
                            state_d = PRESS_PEND;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                PRESS_PEND: begin
                    if (!pressed_now) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!pressed_now) begin
                        if (DEBOUNCE_TICKS == 1) begin
                            state_d   = IDLE;
                            release_d = 1'b1;
                        end else begin
                            state_d = REL_PEND;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                default: begin
                    if (pressed_now) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            endcase
        end
    end

`ifdef CTRL_AUTO_REPEAT_EN
    logic [CNT_W-1:0] rep_q, rep_d;
    logic             rep_first_q, rep_first_d;
    logic             rep_fire;

    // Counts only ticks spent in HELD and staying there; REL_PEND leaves it frozen.
    always_comb begin
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
        rep_fire    = 1'b0;
        if (press_d || state_q == IDLE) begin
            rep_d       = '0;
            rep_first_d = 1'b0;
        end else if (tick_i && state_q == HELD && state_d == HELD) begin
            if (!rep_first_q) begin
                if (rep_q == CNT_W'(REPEAT_DELAY - 1)) begin
                    rep_fire    = 1'b1;
                    rep_d       = '0;
                    rep_first_d = 1'b1;
                end else begin
                    rep_d = rep_q + CNT_ONE;
                end
            end else if (rep_q == CNT_W'(REPEAT_RATE - 1)) begin
                rep_fire = 1'b1;
                rep_d    = '0;
            end else begin
                rep_d = rep_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_q       <= '0;
            rep_first_q <= 1'b0;
        end else begin
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
        end
    end

    assign press_evt = press_d | rep_fire;
`else
    assign press_evt = press_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= {2{IDLE_LVL}};
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], raw_i};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_evt;
            release_q <= release_d;
        end
    end

    // HELD and REL_PEND both have bit 1 set: the pressed level.
    assign level_o   = state_q[1];
    assign level_d_o = state_d[1];
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

`default_nettype wire

// File: rtl/controller_debounce_bank.sv
// ============================================================================
// controller_debounce_bank : shared sample prescaler, NUM_CH debounce channels
// Optional auto-repeat: define CTRL_AUTO_REPEAT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module controller_debounce_bank
    import controller_pkg::*;
#(
    parameter int NUM_CH         = 6,
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int ACTIVE_LOW     = 1,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_RATE    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] raw_in,
    output logic [NUM_CH-1:0] level_out,
    output logic [NUM_CH-1:0] press_pulse,
    output logic [NUM_CH-1:0] release_pulse,
    output logic              any_active
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]     presc_q, presc_d;
    logic              tick;
    logic              any_active_q;
    logic [NUM_CH-1:0] level_d;

    assign tick    = (presc_q == PW'(TICK_DIV - 1));
    assign presc_d = tick ? '0 : presc_q + PW'(1);

    // Fed from next-state levels so any_active lines up with level_out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q      <= '0;
            any_active_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            any_active_q <= |level_d;
        end
    end

    assign any_active = any_active_q;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            debounce_channel #(
                .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
                .ACTIVE_LOW     (ACTIVE_LOW),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_RATE    (REPEAT_RATE)
            ) u_ch (
                .clk       (clk),
                .reset     (reset),
                .tick_i    (tick),
                .raw_i     (raw_in[g]),
                .level_o   (level_out[g]),
                .level_d_o (level_d[g]),
                .press_o   (press_pulse[g]),
                .release_o (release_pulse[g])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_controller_debounce_bank.sv
// ============================================================================
// tb_controller_debounce_bank : directed + random stimulus vs sample-history model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_controller_debounce_bank;

    localparam int NUM_CH = 6;
    localparam int DIV    = 4;
    localparam int DT     = 3;
    localparam int AL     = 1;
    localparam int RD     = 5;
    localparam int RR     = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] raw_in;
    logic [NUM_CH-1:0] level_out, press_pulse, release_pulse;
    logic              any_active;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    controller_debounce_bank #(
        .NUM_CH(NUM_CH), .TICK_DIV(DIV), .DEBOUNCE_TICKS(DT),
        .ACTIVE_LOW(AL), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .reset(reset), .raw_in(raw_in),
        .level_out(level_out), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .any_active(any_active)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a level flips once the last DT tick samples all disagree with it.
    logic [NUM_CH-1:0] m_s1, m_s2, m_level, m_press, m_rel;
    logic [DT-1:0]     m_hist [NUM_CH];
    int                m_presc;
    int                m_rep   [NUM_CH];
    bit                m_first [NUM_CH];
    bit                m_prev  [NUM_CH];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_s1 = '1; m_s2 = '1; m_level = '0; m_press = '0; m_rel = '0; m_presc = 0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_hist[c] = '0; m_rep[c] = 0; m_first[c] = 0; m_prev[c] = 0;
            end
        end else begin
            m_press = '0;
            m_rel   = '0;
            if (m_presc == DIV - 1) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    logic smp;
                    smp = m_s2[c] ^ 1'b1;
                    m_hist[c] = {m_hist[c][DT-2:0], smp};
                    if (m_hist[c] == {DT{~m_level[c]}}) begin
                        m_level[c] = ~m_level[c];
                        if (m_level[c]) m_press[c] = 1'b1;
                        else            m_rel[c]   = 1'b1;
                        m_rep[c] = 0; m_first[c] = 0;
                    end
`ifdef CTRL_AUTO_REPEAT_EN
                    else if (m_level[c] && m_prev[c] && smp) begin
                        m_rep[c]++;
                        if (m_rep[c] == (m_first[c] ? RR : RD)) begin
                            m_press[c] = 1'b1; m_rep[c] = 0; m_first[c] = 1;
                        end
                    end
`endif
                    m_prev[c] = smp;
                end
            end
            m_presc = (m_presc + 1) % DIV;
            m_s2 = m_s1;
            m_s1 = raw_in;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("level",   32'(level_out),     32'(m_level));
            check("press",   32'(press_pulse),   32'(m_press));
            check("release", 32'(release_pulse), 32'(m_rel));
            check("any",     32'(any_active),    32'(|m_level));
            check("excl",    32'(press_pulse & release_pulse), 32'd0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, presses, rels;
        bit found;
        reset  = 1'b1;
        raw_in = '1;
        step(3);
        check("rst_level", 32'(level_out), 0);
        check("rst_press", 32'(press_pulse), 0);
        check("rst_rel",   32'(release_pulse), 0);
        check("rst_any",   32'(any_active), 0);
        chk_en = 1'b1;
        reset  = 1'b0;
        presses = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (press_pulse != 0 || release_pulse != 0) presses++;
        end
        check("idle_pulses", 32'(presses), 0);

        // single press on ch0
        raw_in[0] = 1'b0;
        lat = -1; presses = 0;
        for (int c = 1; c <= 30; c++) begin
            step(1);
            if (press_pulse[0]) presses++;
            if (level_out[0] && lat < 0) lat = c;
        end
        check("press_latency_ok", 32'(lat >= 1 && lat <= 15), 1);
        check("press_once", 32'(presses), 1);
        check("press_any", 32'(any_active), 1);

        // short glitches on ch2 must be filtered
        presses = 0;
        for (int r = 0; r < 5; r++) begin
            raw_in[2] = 1'b0;
            for (int i = 0; i < 6; i++) begin
                step(1);
                if (level_out[2] || press_pulse[2] || release_pulse[2]) presses++;
            end
            raw_in[2] = 1'b1;
            for (int i = 0; i < 6; i++) begin
                step(1);
                if (level_out[2] || press_pulse[2] || release_pulse[2]) presses++;
            end
        end
        check("glitch_filtered", 32'(presses), 0);

        // release ch0
        raw_in[0] = 1'b1;
        lat = -1; rels = 0;
        for (int c = 1; c <= 30; c++) begin
            step(1);
            if (release_pulse[0]) begin
                rels++;
                if (lat < 0) lat = c;
            end
        end
        check("release_latency_ok", 32'(lat >= 1 && lat <= 15), 1);
        check("release_once", 32'(rels), 1);
        check("release_level", 32'(level_out[0]), 0);
        check("release_any", 32'(any_active), 0);

        // simultaneous press on ch0 and ch5
        raw_in[0] = 1'b0; raw_in[5] = 1'b0;
        found = 0;
        for (int c = 0; c < 30; c++) begin
            step(1);
            if (!found && (press_pulse[0] || press_pulse[5])) begin
                found = 1;
                check("press_same_cycle", 32'({press_pulse[5], press_pulse[0]}), 32'b11);
            end
        end
        check("press_seen", 32'(found), 1);

        // reset while ch5 is pending, ch0 held
        raw_in[5] = 1'b1;
        step(30);
        raw_in[5] = 1'b0;
        step(7);
        check("pre_rst_any", 32'(any_active), 1);
        reset = 1'b1;
        #1;
        check("async_rst_level", 32'(level_out), 0);
        check("async_rst_any",   32'(any_active), 0);
        step(3);
        reset = 1'b0;
        presses = 0;
        for (int c = 0; c < 40; c++) begin
            step(1);
            if (press_pulse[5]) presses++;
        end
        check("fresh_press_ch5", 32'(presses), 1);
        check("fresh_level_ch5", 32'(level_out[5]), 1);

        // random activity, with an occasional mid-run reset
        raw_in = '1;
        step(40);
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(0, (i < 1500) ? 7 : 39) == 0) raw_in[c] = ~raw_in[c];
            if (i == 2200) reset = 1'b1;
            if (i == 2203) reset = 1'b0;
            step(1);
        end

`ifdef CTRL_AUTO_REPEAT_EN
        begin
            int t [$];
            raw_in = '1;
            step(40);
            raw_in[4] = 1'b0;
            for (int c = 0; c < 60; c++) begin
                step(1);
                if (press_pulse[4]) t.push_back(c);
            end
            check("repeat_count_ge3", 32'(t.size() >= 3), 1);
            if (t.size() >= 3) begin
                check("repeat_first_gap", 32'(t[1] - t[0]), 20);
                check("repeat_rate_gap",  32'(t[2] - t[1]), 8);
            end
            raw_in = '1;
            step(30);
        end
`endif

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
